cosim_mmio_bridge: RTL and testbench



---
 rtl/cosim_dpi_pkg.sv | 61 ++++++
 rtl/cosim_mmio_bridge_pkg.sv | 25 ++
 rtl/cosim_mmio_bridge.sv | 185 ++++++++++++++++++
 tb/tb_cosim_mmio_bridge.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cosim_dpi_pkg.sv
// Cosim MMIO server endpoint. Carries the same function names and signatures
// as the DPI imports, backed by SystemVerilog state so a pure-SV simulation
// can stand in for the host. Request rings are filled by the host side and
// drained by the bridge; every respond call is appended to rsp_log as
// {write, data[31:0], error[7:0]}.
package cosim_dpi_pkg;

  // Host-side request rings: the host owns the tail, the bridge owns the head.
  int unsigned rd_addr_tab [64];
  int unsigned wr_addr_tab [64];
  int unsigned wr_data_tab [64];
  bit [5:0]    rd_head = '0;
  bit [5:0]    rd_tail = '0;
  bit [5:0]    wr_head = '0;
  bit [5:0]    wr_tail = '0;

  // Server-side bookkeeping.
  int          register_result = 0;
  int          register_calls  = 0;
  int          poll_count      = 0;
  int          get_count       = 0;
  logic [40:0] rsp_log [$];

  function automatic int cosim_mmio_register();
    register_calls++;
    return register_result;
  endfunction

  // Returns 0 when a request was obtained, nonzero when nothing is pending.
  function automatic int cosim_mmio_read_tryget(output int unsigned address);
    poll_count++;
    address = 0;
    if (rd_head == rd_tail) return 1;
    address = rd_addr_tab[rd_head];
    rd_head++;
    get_count++;
    return 0;
  endfunction

  function automatic int cosim_mmio_write_tryget(output int unsigned address,
                                                 output int unsigned data);
    poll_count++;
    address = 0;
    data    = 0;
    if (wr_head == wr_tail) return 1;
    address = wr_addr_tab[wr_head];
    data    = wr_data_tab[wr_head];
    wr_head++;
    get_count++;
    return 0;
  endfunction

  function automatic void cosim_mmio_read_respond(input int unsigned data, input byte err);
    rsp_log.push_back({1'b0, 32'(data), 8'(err)});
  endfunction

  function automatic void cosim_mmio_write_respond(input byte err);
    rsp_log.push_back({1'b1, 32'h0, 8'(err)});
  endfunction

endpackage

// File: rtl/cosim_mmio_bridge_pkg.sv
// Shared types and constants for the cosim MMIO bridge.
package cosim_mmio_bridge_pkg;

  typedef enum logic [2:0] {
    ST_REGISTER,
    ST_DISABLED,
    ST_IDLE,
    ST_CMD,
    ST_WAIT
  } state_t;

  // Error byte codes handed back to the host through the respond calls.
  localparam logic [7:0] ERR_OK         = 8'd0;
  localparam logic [7:0] ERR_DEVICE     = 8'd1;
  localparam logic [7:0] ERR_TIMEOUT    = 8'd2;
  localparam logic [7:0] ERR_MISALIGNED = 8'd3;
  localparam logic [7:0] ERR_RESET      = 8'd4;

  typedef struct packed {
    logic        write;
    logic [31:0] address;
    logic [31:0] data;
  } mmio_req_t;

endpackage

// File: rtl/cosim_mmio_bridge.sv
// Cosim MMIO bridge: polls the cosim server for host MMIO requests, issues
// each one as a single-beat command on the MMIO bus and returns the design's
// response (or an error code) through the matching respond call.
//
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
// cmd_valid and the command fields hold until then (timeout and reset are the
// only exceptions). Exactly one request is outstanding; the bridge is always
// ready for rsp_valid in WAIT and any rsp_valid elsewhere is a protocol error.
module cosim_mmio_bridge
  import cosim_mmio_bridge_pkg::*;
  import cosim_dpi_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int POLL_INTERVAL  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_write,
  output logic [31:0] cmd_address,
  output logic [31:0] cmd_data,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  input  logic        rsp_error,
  output logic        enabled,
  output logic        protocol_err
);

  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int PI = (POLL_INTERVAL > 1) ? POLL_INTERVAL : 1;
  localparam int PW = (PI > 1) ? $clog2(PI) : 1;
  localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [PW-1:0] POLL_RELOAD = PW'(PI - 1);

  state_t        state;
  state_t        next_state;
  mmio_req_t     req;
  logic [TW-1:0] tmo_cnt;
  logic [PW-1:0] poll_cnt;
  logic          rr_write;
  logic          tmo_hit;
  logic          poll_now;
  logic          handshake;

  // Registration outcome and reset-abort record deliberately survive rst_n:
  // registration happens once per simulation, and a request cut off by reset
  // must still be answered after release.
  bit reg_done;
  bit reg_ok;
  bit abort_pending;
  bit abort_write;

  function automatic void respond(input logic write, input logic [31:0] data,
                                  input logic [7:0] err);
    if (write) cosim_mmio_write_respond(err);
    else       cosim_mmio_read_respond(data, err);
  endfunction

  // Output decode and next-state for transitions that depend only on the bus.
  // Transitions that depend on a server call result are resolved on the edge.
  always_comb begin
    cmd_valid   = (state == ST_CMD);
    cmd_write   = req.write;
    cmd_address = req.address;
    cmd_data    = req.data;
    handshake   = cmd_valid && cmd_ready;
    tmo_hit     = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST);
    poll_now    = (state == ST_IDLE) && (poll_cnt == '0);
    next_state  = state;
    case (state)
      ST_REGISTER: next_state = reg_ok ? ST_IDLE : ST_DISABLED;
      ST_DISABLED: next_state = ST_DISABLED;
      ST_IDLE:     next_state = ST_IDLE;
      ST_CMD: begin
        if (tmo_hit)        next_state = ST_IDLE;
        else if (handshake) next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (rsp_valid || tmo_hit) next_state = ST_IDLE;
      end
      default: next_state = ST_REGISTER;
    endcase
  end

  // State register, server calls, request latch, timeout and poll counters.
  always_ff @(posedge clk or negedge rst_n) begin : fsm_seq
    int unsigned poll_addr;
    int unsigned poll_data;
    if (!rst_n) begin
      if (state == ST_CMD || state == ST_WAIT) begin
        abort_pending <= 1'b1;
        abort_write   <= req.write;
      end
      state        <= ST_REGISTER;
      req          <= '0;
      tmo_cnt      <= '0;
      poll_cnt     <= '0;
      rr_write     <= 1'b0;
      enabled      <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      state <= next_state;
      if (rsp_valid && state != ST_WAIT) protocol_err <= 1'b1;
      case (state)
        ST_REGISTER: begin
          // Answer a request orphaned by reset before anything else happens.
          if (abort_pending) begin
            respond(abort_write, 32'h0, ERR_RESET);
            abort_pending <= 1'b0;
          end
          if (!reg_done) begin
            reg_done <= 1'b1;
            if (cosim_mmio_register() == 0) begin
              reg_ok  <= 1'b1;
              enabled <= 1'b1;
              state   <= ST_IDLE;
            end else begin
              reg_ok <= 1'b0;
              state  <= ST_DISABLED;
              $error("cosim_mmio_bridge: MMIO registration failed, bridge disabled");
            end
          end else if (reg_ok) begin
            enabled <= 1'b1;
          end
          poll_cnt <= '0;
        end
        ST_IDLE: begin
          if (poll_now) begin
            poll_cnt <= POLL_RELOAD;
            rr_write <= !rr_write;
            if (!rr_write) begin
              if (cosim_mmio_read_tryget(poll_addr) == 0) begin
                if (poll_addr[1:0] != 2'b00) begin
                  respond(1'b0, 32'h0, ERR_MISALIGNED);
                end else begin
                  req.write   <= 1'b0;
                  req.address <= poll_addr;
                  req.data    <= 32'h0;
                  tmo_cnt     <= '0;
                  state       <= ST_CMD;
                end
              end
            end else begin
              if (cosim_mmio_write_tryget(poll_addr, poll_data) == 0) begin
                if (poll_addr[1:0] != 2'b00) begin
                  respond(1'b1, 32'h0, ERR_MISALIGNED);
                end else begin
                  req.write   <= 1'b1;
                  req.address <= poll_addr;
                  req.data    <= poll_data;
                  tmo_cnt     <= '0;
                  state       <= ST_CMD;
                end
              end
            end
          end else begin
            poll_cnt <= poll_cnt - 1'b1;
          end
        end
        ST_CMD: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (tmo_hit) begin
            respond(req.write, 32'h0, ERR_TIMEOUT);
            poll_cnt <= '0;
          end
        end
        ST_WAIT: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          // A response arriving on the expiry edge still wins over the timeout.
          if (rsp_valid) begin
            respond(req.write, req.write ? 32'h0 : rsp_data,
                    rsp_error ? ERR_DEVICE : ERR_OK);
            poll_cnt <= '0;
          end else if (tmo_hit) begin
            respond(req.write, 32'h0, ERR_TIMEOUT);
            poll_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cosim_mmio_bridge.sv
// Directed bench for cosim_mmio_bridge: host requests are placed in the
// server rings, the design side is driven by hand, and every respond call
// is compared against hand-computed expectations.
module tb_cosim_mmio_bridge;
  import cosim_mmio_bridge_pkg::*;
  import cosim_dpi_pkg::*;

  localparam int W = 41;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_ready = 1'b0;
  logic        rsp_valid = 1'b0;
  logic        rsp_error = 1'b0;
  logic [31:0] rsp_data = 32'h0;
  logic        cmd_valid;
  logic        cmd_write;
  logic [31:0] cmd_address;
  logic [31:0] cmd_data;
  logic        enabled;
  logic        protocol_err;

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int log_idx = 0;

  // Clock and timeout watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  cosim_mmio_bridge #(
    .TIMEOUT_CYCLES(8),
    .POLL_INTERVAL(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_address(cmd_address),
    .cmd_data(cmd_data),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .rsp_error(rsp_error),
    .enabled(enabled),
    .protocol_err(protocol_err)
  );

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push_read(input logic [31:0] a);
    rd_addr_tab[rd_tail] = a;
    rd_tail++;
  endtask

  task automatic push_write(input logic [31:0] a, input logic [31:0] d);
    wr_addr_tab[wr_tail] = a;
    wr_data_tab[wr_tail] = d;
    wr_tail++;
  endtask

  task automatic exp_rsp(input logic write, input logic [31:0] data, input logic [7:0] err);
    exp_q.push_back({write, data, err});
  endtask

  // Compare all new respond calls against the expected queue, in order.
  task automatic check_log(input string tag);
    check({tag, "_count"}, 72'(rsp_log.size() - log_idx), 72'(exp_q.size()));
    while (exp_q.size() > 0 && log_idx < rsp_log.size()) begin
      check(tag, 72'(rsp_log[log_idx]), 72'(exp_q.pop_front()));
      log_idx++;
    end
    exp_q.delete();
  endtask

  // Wait (bounded) for cmd_valid; the tryget must be on the edge just before.
  task automatic wait_cmd(input string tag, output logic found);
    int gets_prev;
    found = 1'b0;
    gets_prev = get_count;
    for (int i = 0; i < 6 && !found; i++) begin
      @(negedge clk);
      if (cmd_valid) begin
        found = 1'b1;
        check({tag, "_lat"}, 72'(get_count - gets_prev), 72'd1);
      end else begin
        gets_prev = get_count;
      end
    end
    check({tag, "_seen"}, 72'(found), 72'd1);
  endtask

  // One-cycle response pulse starting at the current falling edge.
  task automatic pulse_rsp(input logic [31:0] d, input logic e);
    rsp_valid = 1'b1;
    rsp_data  = d;
    rsp_error = e;
    @(negedge clk);
    rsp_valid = 1'b0;
    rsp_data  = 32'h0;
    rsp_error = 1'b0;
  endtask

  initial begin
    logic found;
    logic saw;
    logic w0;
    logic w1;
    int   polls_snap;
    int   gets_snap;
    int   k_hit;

    // Reset values.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 72'(cmd_valid), 72'd0);
    check("rst_fields", 72'({cmd_write, cmd_address, cmd_data}), 72'd0);
    check("rst_flags", 72'({enabled, protocol_err}), 72'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reg_enabled", 72'(enabled), 72'd1);
    check("reg_calls", 72'(register_calls), 72'd1);

    // Read 0x10, ready tied high, response two cycles after accept.
    cmd_ready = 1'b1;
    push_read(32'h0000_0010);
    wait_cmd("rd", found);
    polls_snap = poll_count;
    check("rd_fields", 72'({cmd_write, cmd_address, cmd_data}), 72'({1'b0, 32'h10, 32'h0}));
    @(negedge clk);
    check("rd_valid_one_cycle", 72'(cmd_valid), 72'd0);
    @(negedge clk);
    pulse_rsp(32'hDEAD_BEEF, 1'b0);
    exp_rsp(1'b0, 32'hDEAD_BEEF, ERR_OK);
    check_log("rd_rsp");
    check("rd_no_poll_busy", 72'(poll_count - polls_snap), 72'd0);

    // Write 0x20 = 0x1234 with ready low for five cycles, design error.
    cmd_ready = 1'b0;
    push_write(32'h20, 32'h1234);
    wait_cmd("wr", found);
    for (int i = 0; i < 5; i++) begin
      check("wr_hold", 72'({cmd_valid, cmd_write, cmd_address, cmd_data}),
            72'({1'b1, 1'b1, 32'h20, 32'h1234}));
      if (i < 4) @(negedge clk);
    end
    cmd_ready = 1'b1;
    @(negedge clk);
    check("wr_valid_drop", 72'(cmd_valid), 72'd0);
    pulse_rsp(32'hFFFF_FFFF, 1'b1);
    exp_rsp(1'b1, 32'h0, ERR_DEVICE);
    check_log("wr_rsp");

    // Read with no response: timeout eight cycles after entering CMD.
    push_read(32'h40);
    wait_cmd("tmo", found);
    k_hit = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k_hit == 0 && rsp_log.size() > log_idx) k_hit = k;
    end
    check("tmo_cycles", 72'(k_hit), 72'd8);
    exp_rsp(1'b0, 32'h0, ERR_TIMEOUT);
    check_log("tmo_rsp");
    check("tmo_valid_low", 72'(cmd_valid), 72'd0);
    check("tmo_perr_before", 72'(protocol_err), 72'd0);
    pulse_rsp(32'h1, 1'b0);
    check("tmo_perr_late_rsp", 72'(protocol_err), 72'd1);

    // Misaligned read: error 3, no bus traffic.
    saw = 1'b0;
    push_read(32'h13);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (cmd_valid) saw = 1'b1;
    end
    check("mis_no_cmd", 72'(saw), 72'd0);
    exp_rsp(1'b0, 32'h0, ERR_MISALIGNED);
    check_log("mis_rsp");

    // Read and write both pending: alternating, one at a time.
    push_read(32'h100);
    push_write(32'h104, 32'hAA);
    w0 = 1'b0;
    w1 = 1'b0;
    for (int t = 0; t < 2; t++) begin
      wait_cmd("alt", found);
      if (t == 0) w0 = cmd_write;
      else        w1 = cmd_write;
      if (cmd_write)
        check("alt_wr_fields", 72'({cmd_address, cmd_data}), 72'({32'h104, 32'hAA}));
      else
        check("alt_rd_fields", 72'({cmd_address, cmd_data}), 72'({32'h100, 32'h0}));
      check("alt_one_outstanding", 72'(rsp_log.size() - log_idx), 72'(t));
      if (cmd_write) exp_rsp(1'b1, 32'h0, ERR_OK);
      else           exp_rsp(1'b0, 32'hCAFE_0000 + 32'(t), ERR_OK);
      @(negedge clk);
      pulse_rsp(32'hCAFE_0000 + 32'(t), 1'b0);
    end
    check("alt_order", 72'(w0 ^ w1), 72'd1);
    check_log("alt_rsp");

    // Reset during WAIT of a write: answered with error 4 before new work.
    push_write(32'h200, 32'h55);
    wait_cmd("abort", found);
    @(negedge clk);
    check("abort_in_wait", 72'(cmd_valid), 72'd0);
    rst_n = 1'b0;
    push_read(32'h300);
    gets_snap = get_count;
    @(negedge clk);
    check("abort_rst_flags", 72'({cmd_valid, enabled, protocol_err}), 72'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_reg_once", 72'(register_calls), 72'd1);
    check("abort_enabled", 72'(enabled), 72'd1);
    check("abort_before_new", 72'(get_count - gets_snap), 72'd0);
    exp_rsp(1'b1, 32'h0, ERR_RESET);
    check_log("abort_rsp");
    wait_cmd("post", found);
    check("post_fields", 72'({cmd_write, cmd_address}), 72'({1'b0, 32'h300}));
    @(negedge clk);
    pulse_rsp(32'h77, 1'b0);
    exp_rsp(1'b0, 32'h77, ERR_OK);
    check_log("post_rsp");

    check("log_drained", 72'(rsp_log.size() - log_idx), 72'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
